// File: rtl/sm83_bus_ctl.sv
// sm83_bus_ctl: T-state driven bus controller latching address/data and generating rd/wr/doe strobes.
// Define SM83_BUS_CHECKS_EN to include the input assumptions and strobe-consistency assertions.
module sm83_bus_ctl (
    input  logic        clk,
    input  logic        reset,
    input  logic        t1,
    input  logic        t2,
    input  logic        t3,
    input  logic        t4,
    input  logic        m1,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] adr_in,
    input  logic [7:0]  dout,
    input  logic [7:0]  din,
    output logic [15:0] adr,
    output logic        rd,
    output logic        wr,
    output logic        doe,
    output logic [7:0]  dbus,
    output logic [7:0]  ir,
    output logic [7:0]  dl,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
    state_t state;
    logic   fetch;
    logic   is_rd;
    always_comb is_rd = m1 || rd_req;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            fetch <= 1'b0;
            adr   <= 16'h0000;
            dbus  <= 8'h00;
            ir    <= 8'h00;
            dl    <= 8'h00;
            rd    <= 1'b0;
            wr    <= 1'b0;
            doe   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            if (t1) begin
                adr   <= adr_in;
                dbus  <= dout;
                fetch <= m1;
                state <= is_rd ? READ : wr_req ? WRITE : IDLE;
                busy  <= is_rd || wr_req;
                rd    <= is_rd;
                doe   <= !is_rd && wr_req;
                wr    <= 1'b0;
            end
            if (t2 && state == WRITE)
                wr <= 1'b1;
            // Read data is captured into ir for opcode fetches, dl otherwise.
            if (t3) begin
                rd <= 1'b0;
                wr <= 1'b0;
                if (state == READ && fetch)
                    ir <= din;
                if (state == READ && !fetch)
                    dl <= din;
            end
            if (t4) begin
                state <= IDLE;
                busy  <= 1'b0;
                doe   <= 1'b0;
            end
        end
    end
`ifdef SM83_BUS_CHECKS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            assume ($onehot({t1, t2, t3, t4}));
            if (t1)
                assume (!(rd_req && wr_req && !m1));
            assert (!(rd && wr));
            assert (!doe || state == WRITE);
        end
    end
`endif
endmodule

// File: tb/tb_sm83_bus_ctl.sv
// tb_sm83_bus_ctl: directed T-state sequences with hand-computed expectations for sm83_bus_ctl.
module tb_sm83_bus_ctl;
    logic        clk = 1'b0;
    logic        reset, t1, t2, t3, t4, m1, rd_req, wr_req;
    logic [15:0] adr_in, adr;
    logic [7:0]  dout, din, dbus, ir, dl;
    logic        rd, wr, doe, busy;
    int          checks = 0;
    int          errors = 0;

    sm83_bus_ctl dut (
        .clk(clk), .reset(reset), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .m1(m1), .rd_req(rd_req), .wr_req(wr_req), .adr_in(adr_in),
        .dout(dout), .din(din), .adr(adr), .rd(rd), .wr(wr), .doe(doe),
        .dbus(dbus), .ir(ir), .dl(dl), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        @(negedge clk);
        {t1, t2, t3, t4} = {n == 1, n == 2, n == 3, n == 4};
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        {t1, t2, t3, t4} = 4'b0000;
        reset = 1'b1; m1 = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
        adr_in = 16'h1234; dout = 8'h77; din = 8'h00;
        // reset coincident with t1 must win
        step(1);
        chk("rst_adr", adr, 16'h0000);
        chk("rst_dbus", {8'h00, dbus}, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_rd", {15'd0, rd}, 16'h0000);
        chk("rst_wr", {15'd0, wr}, 16'h0000);
        chk("rst_doe", {15'd0, doe}, 16'h0000);
        chk("rst_ir", {8'h00, ir}, 16'h0000);
        chk("rst_dl", {8'h00, dl}, 16'h0000);
        step(4);
        reset = 1'b0;

        // opcode fetch
        m1 = 1'b1; adr_in = 16'h0100; din = 8'h00;
        step(1);
        chk("f_rd_t2", {15'd0, rd}, 16'h0001);
        chk("f_busy", {15'd0, busy}, 16'h0001);
        chk("f_adr", adr, 16'h0100);
        m1 = 1'b0; adr_in = 16'hDEAD;
        step(2);
        chk("f_rd_t3", {15'd0, rd}, 16'h0001);
        din = 8'h3E;
        step(3);
        chk("f_rd_t4", {15'd0, rd}, 16'h0000);
        chk("f_ir", {8'h00, ir}, 16'h003E);
        chk("f_dl", {8'h00, dl}, 16'h0000);
        step(4);
        chk("f_busy_end", {15'd0, busy}, 16'h0000);
        chk("f_adr_hold", adr, 16'h0100);

        // data read
        m1 = 1'b0; rd_req = 1'b1; adr_in = 16'hC000;
        step(1);
        chk("r_rd", {15'd0, rd}, 16'h0001);
        chk("r_wr_t2", {15'd0, wr}, 16'h0000);
        rd_req = 1'b0;
        step(2);
        chk("r_wr_t3", {15'd0, wr}, 16'h0000);
        din = 8'hA5;
        step(3);
        chk("r_dl", {8'h00, dl}, 16'h00A5);
        chk("r_ir", {8'h00, ir}, 16'h003E);
        step(4);
        chk("r_busy_end", {15'd0, busy}, 16'h0000);

        // data write
        wr_req = 1'b1; adr_in = 16'hFF80; dout = 8'h5A; din = 8'h77;
        step(1);
        chk("w_doe_t2", {15'd0, doe}, 16'h0001);
        chk("w_wr_t2", {15'd0, wr}, 16'h0000);
        chk("w_rd_t2", {15'd0, rd}, 16'h0000);
        chk("w_dbus", {8'h00, dbus}, 16'h005A);
        chk("w_adr", adr, 16'hFF80);
        wr_req = 1'b0; dout = 8'h00; adr_in = 16'h0000;
        step(2);
        chk("w_wr_t3", {15'd0, wr}, 16'h0001);
        chk("w_doe_t3", {15'd0, doe}, 16'h0001);
        step(3);
        chk("w_wr_t4", {15'd0, wr}, 16'h0000);
        chk("w_doe_t4", {15'd0, doe}, 16'h0001);
        chk("w_dl_hold", {8'h00, dl}, 16'h00A5);
        step(4);
        chk("w_doe_end", {15'd0, doe}, 16'h0000);
        chk("w_busy_end", {15'd0, busy}, 16'h0000);
        chk("w_dbus_hold", {8'h00, dbus}, 16'h005A);
        chk("w_adr_hold", adr, 16'hFF80);

        // idle cycle still latches adr/dbus
        adr_in = 16'h1111; dout = 8'h22;
        step(1);
        chk("i_busy", {15'd0, busy}, 16'h0000);
        chk("i_adr", adr, 16'h1111);
        chk("i_dbus", {8'h00, dbus}, 16'h0022);
        chk("i_rd", {15'd0, rd}, 16'h0000);
        step(2); step(3);
        chk("i_ir", {8'h00, ir}, 16'h003E);
        step(4);

        // rd_req and wr_req together: read wins
        rd_req = 1'b1; wr_req = 1'b1; adr_in = 16'h2000;
        step(1);
        chk("b_rd", {15'd0, rd}, 16'h0001);
        chk("b_doe", {15'd0, doe}, 16'h0000);
        rd_req = 1'b0; wr_req = 1'b0;
        step(2);
        chk("b_wr", {15'd0, wr}, 16'h0000);
        din = 8'h99;
        step(3);
        chk("b_dl", {8'h00, dl}, 16'h0099);
        step(4);

        // m1 with wr_req: fetch only
        m1 = 1'b1; wr_req = 1'b1; adr_in = 16'h0000;
        step(1);
        chk("m_rd", {15'd0, rd}, 16'h0001);
        chk("m_doe", {15'd0, doe}, 16'h0000);
        m1 = 1'b0; wr_req = 1'b0;
        step(2);
        chk("m_wr", {15'd0, wr}, 16'h0000);
        din = 8'hC3;
        step(3);
        chk("m_ir", {8'h00, ir}, 16'h00C3);
        chk("m_dl", {8'h00, dl}, 16'h0099);
        step(4);

        // reset in the middle of a read aborts it
        rd_req = 1'b1; adr_in = 16'h8000;
        step(1);
        rd_req = 1'b0;
        reset = 1'b1;
        step(2);
        chk("a_rd", {15'd0, rd}, 16'h0000);
        chk("a_ir", {8'h00, ir}, 16'h0000);
        chk("a_dl", {8'h00, dl}, 16'h0000);
        chk("a_adr", adr, 16'h0000);
        chk("a_busy", {15'd0, busy}, 16'h0000);
        reset = 1'b0; din = 8'h55;
        step(3);
        chk("a_no_cap_dl", {8'h00, dl}, 16'h0000);
        chk("a_no_cap_ir", {8'h00, ir}, 16'h0000);
        step(4);

        // first access after reset starts at the next t1
        m1 = 1'b1; adr_in = 16'h0150;
        step(1);
        chk("n_rd", {15'd0, rd}, 16'h0001);
        chk("n_adr", adr, 16'h0150);
        m1 = 1'b0; din = 8'h00;
        step(2); step(3);
        chk("n_ir", {8'h00, ir}, 16'h0000);
        step(4);
        chk("n_busy_end", {15'd0, busy}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
